// File: rtl/fifo_wr_burst_ctrl.sv
// Burst write controller: moves BURST_LENGTH source words into a FIFO, with WRITE_PERIOD idle cycles after each write.
// Latency: winc/src_ready/wdata are combinational in WRITE; busy/done/aborted are registered and follow the state by one edge.
// Backpressure: wfull or src_valid=0 holds WRITE with no write and no timeout; wfull cycles are counted in stall_count.
module fifo_wr_burst_ctrl #(
  parameter int DATASIZE     = 9,
  parameter int BURST_LENGTH = 1024,
  parameter int WRITE_PERIOD = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                src_valid,
  input  logic [DATASIZE-1:0] src_data,
  output logic                src_ready,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [10:0]         wr_count,
  output logic [15:0]         stall_count
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

  // wr_count value seen on the edge of the final write of a burst
  localparam logic [10:0] LAST_WR  = 11'(BURST_LENGTH - 1);
  // gap counter value in the final GAP cycle
  localparam logic [1:0]  GAP_LAST = 2'((WRITE_PERIOD > 0) ? (WRITE_PERIOD - 1) : 0);

  state_t      state_q, state_d;
  logic [1:0]  gap_q, gap_d;
  logic [10:0] wr_count_q, wr_count_d;
  logic [15:0] stall_q, stall_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  // FIFO write happens only in WRITE with a word available, room in the FIFO and no abort
  assign winc        = (state_q == S_WRITE) & src_valid & ~wfull & ~abort;
  assign src_ready   = winc;
  assign wdata       = src_data;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign wr_count    = wr_count_q;
  assign stall_count = stall_q;

  // Next-state and counter update logic
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    wr_count_d = wr_count_q;
    stall_d    = stall_q;
    aborted_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_WRITE;
          gap_d      = 2'd0;
          wr_count_d = 11'd0;
          stall_d    = 16'd0;
        end
      end
      S_WRITE: begin
        // blocked cycles are counted even when the burst is being aborted
        if (wfull && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (winc) begin
          wr_count_d = wr_count_q + 11'd1;
          if (wr_count_q == LAST_WR) begin
            state_d = S_DONE;
          end else if (WRITE_PERIOD > 0) begin
            state_d = S_GAP;
            gap_d   = 2'd0;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_WRITE;
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_WRITE) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered status outputs
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= 2'd0;
      wr_count_q <= 11'd0;
      stall_q    <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wr_count_q <= wr_count_d;
      stall_q    <= stall_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

endmodule

// File: doc/fifo_wr_burst_ctrl.md
FIFO_WR_BURST_CTRL -- requirements
Module: fifo_wr_burst_ctrl

Interface
REQ-001 SHALL have parameter DATASIZE, default 9: width of the FIFO write data word.
REQ-002 SHALL have parameter BURST_LENGTH, default 1024: number of FIFO writes per burst (legal range 1..1024).
REQ-003 SHALL have parameter WRITE_PERIOD, default 2: number of idle cycles inserted after each write (legal range 0..3).
REQ-004 SHALL have port wclk, input, 1 bit: single clock, rising-edge active.
REQ-005 SHALL have port wrst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin a burst.
REQ-007 SHALL have port abort, input, 1 bit: request to terminate the burst in progress.
REQ-008 SHALL have port src_valid, input, 1 bit: source word available.
REQ-009 SHALL have port src_data, input, DATASIZE bits: source word.
REQ-010 SHALL have port src_ready, output, 1 bit: source word consumed this cycle.
REQ-011 SHALL have port wfull, input, 1 bit: FIFO full flag in the wclk domain.
REQ-012 SHALL have port winc, output, 1 bit: FIFO write enable.
REQ-013 SHALL have port wdata, output, DATASIZE bits: FIFO write data.
REQ-014 SHALL have port busy, output, 1 bit: burst in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on burst completion.
REQ-016 SHALL have port aborted, output, 1 bit: one-cycle pulse on burst abort.
REQ-017 SHALL have port wr_count, output, 11 bits: writes issued in the current or last burst.
REQ-018 SHALL have port stall_count, output, 16 bits: cycles spent in WRITE blocked by wfull.

Function
REQ-019 SHALL implement the states IDLE, WRITE, GAP and DONE.
REQ-020 SHALL move from IDLE to WRITE on the edge where start=1 and abort=0, and clear wr_count, stall_count and the gap counter on that edge.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 SHALL drive winc = (state==WRITE) & src_valid & ~wfull & ~abort combinationally; src_ready SHALL equal winc and wdata SHALL equal src_data.
REQ-023 SHALL increment wr_count by 1 on each edge where winc=1.
REQ-024 SHALL, on a write that is not the last one, go to GAP if WRITE_PERIOD>0, otherwise stay in WRITE so that writes can occur back-to-back.
REQ-025 SHALL hold GAP for exactly WRITE_PERIOD cycles with winc=0, then return to WRITE.
REQ-026 SHALL go directly to DONE, with no gap, on the write that brings wr_count to BURST_LENGTH.
REQ-027 SHALL assert done=1 for the single DONE cycle and then return to IDLE.
REQ-028 SHALL stay in WRITE while wfull=1 or src_valid=0, with no write and no timeout.
REQ-029 SHALL increment stall_count on each WRITE cycle with wfull=1, saturating at 16'hFFFF.
REQ-030 SHALL, on abort=1 in WRITE or GAP, force winc=0 that cycle, go to IDLE on the next edge and pulse aborted=1 for one cycle, with no done pulse.
REQ-031 SHALL ignore abort in IDLE and DONE.
REQ-032 SHALL hold wr_count and stall_count after the burst ends until the next accepted start.
REQ-033 SHALL drive busy=1 in WRITE and GAP, and busy=0 in IDLE and DONE.
REQ-034 SHALL never assert winc in a cycle where wfull=1, so that the FIFO cannot overflow.

Reset
REQ-035 SHALL, while wrst_n=0, immediately force state IDLE, gap counter 0, wr_count 0, stall_count 0, busy 0, done 0, aborted 0 and winc 0, independent of wclk.
REQ-036 SHALL discard a burst on reset mid-burst, with no done or aborted pulse, and return to normal operation on the first edge after wrst_n deasserts.

Verification
REQ-037 SHALL verify nominal timing: start at edge 0, src_valid=1, wfull=0 -> winc on cycles 1,4,7,...,3070 (1024 writes), done=1 on cycle 3071, busy=0 from cycle 3071, wr_count=1024.
REQ-038 SHALL verify stall on full: wfull=1 on cycles 4-13 -> no write on cycles 4-13, write on cycle 14, stall_count=10.
REQ-039 SHALL verify abort: abort=1 on cycle 7 with src_valid=1 -> winc=0 on cycle 7, aborted=1 on cycle 8, wr_count=2, no done pulse.
REQ-040 SHALL verify source throttling and back-to-back writes: WRITE_PERIOD=0, BURST_LENGTH=4, src_valid low on cycle 2 only -> winc on cycles 1,3,4,5, done on cycle 6.
REQ-041 SHALL verify reset mid-burst: wrst_n low for one cycle at cycle 100 -> all outputs 0 immediately, state IDLE; a following start runs a full burst with wr_count starting from 0.
REQ-042 SHALL verify start is ignored while busy: start=1 on cycle 50 -> no effect on wr_count or the write timing.
